// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the iterative divider.
//   div_state_t : divider control states
//   DIV_WIDTH   : operand width (32)
//   DIV_STEPS   : restoring steps per division (one per clock)
//   neg32/abs32 : two's-complement helpers used for signed prep and sign fix
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_t;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return (~x) + 32'd1;
  endfunction

  // 0x80000000 maps to itself, which as an unsigned magnitude is exactly 2^31.
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? neg32(x) : x;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
//   signed_div, opdata1, opdata2, start, annul : EX -> divider
//   result {rem, quo}, ready                   : divider -> EX
// master = EX stage side, slave = divider side.
interface div_if;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start;
  logic        annul;
  logic [63:0] result;
  logic        ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-bit MIPS divider for DIV/DIVU, one restoring step per clock.
// Produces {remainder, quotient} for the HI/LO write.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high, overrides everything
//   bus  : div_if.slave (operands, start/annul in; result/ready out)
//
// state       | meaning
// ------------+--------------------------------------------------------
// DIV_FREE    | idle, waiting for start with annul low
// DIV_BY_ZERO | divisor was zero, report result 0 on the next edge
// DIV_ON      | 32 restoring steps in progress
// DIV_END     | result valid, held until EX drops start
module div_unit
  import div_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  div_state_t  state;
  logic [4:0]  cnt;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] dvd;
  logic [31:0] dvsr;
  logic [31:0] rem;
  logic [63:0] result_q;
  logic        ready_q;

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        ge;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;

  // The dividend register doubles as the quotient: its top bit feeds the
  // partial remainder while the new quotient bit enters at the bottom.
  always_comb begin
    shifted = {rem, dvd[31]};
    diff    = shifted - {1'b0, dvsr};
    ge      = (shifted >= {1'b0, dvsr});
    rem_nxt = ge ? diff[31:0] : shifted[31:0];
    quo_nxt = {dvd[30:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= 5'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dvd      <= 32'd0;
      dvsr     <= 32'd0;
      rem      <= 32'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        DIV_FREE: begin
          ready_q  <= 1'b0;
          result_q <= 64'd0;
          if (bus.start && !bus.annul) begin
            neg_q <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
            neg_r <= bus.signed_div & bus.opdata1[31];
            dvd   <= bus.signed_div ? abs32(bus.opdata1) : bus.opdata1;
            dvsr  <= bus.signed_div ? abs32(bus.opdata2) : bus.opdata2;
            rem   <= 32'd0;
            cnt   <= 5'd0;
            state <= (bus.opdata2 == 32'd0) ? DIV_BY_ZERO : DIV_ON;
          end
        end

        DIV_BY_ZERO: begin
          result_q <= 64'd0;
          if (bus.annul) begin
            ready_q <= 1'b0;
            state   <= DIV_FREE;
          end else begin
            ready_q <= 1'b1;
            state   <= DIV_END;
          end
        end

        DIV_ON: begin
          if (bus.annul) begin
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            state    <= DIV_FREE;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + 5'd1;
            if (cnt == 5'(DIV_STEPS - 1)) begin
              result_q <= {neg_r ? neg32(rem_nxt) : rem_nxt,
                           neg_q ? neg32(quo_nxt) : quo_nxt};
              ready_q  <= 1'b1;
              state    <= DIV_END;
            end
          end
        end

        DIV_END: begin
          if (!bus.start) begin
            ready_q  <= 1'b0;
            result_q <= 64'd0;
            state    <= DIV_FREE;
          end
        end

        default: begin
          ready_q  <= 1'b0;
          result_q <= 64'd0;
          state    <= DIV_FREE;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;

endmodule
